// File: rtl/seq_divider_pkg.sv
// Shared core defines for the sequential divider: FSM encoding and default width.
package seq_divider_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider (signed/unsigned), one quotient bit per cycle.
// Optional DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow skip CALC entirely.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_end_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             start_div0;
  logic             start_ovf;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted;
  logic             step_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;
  logic [WIDTH-1:0] quot_signed;
  logic [WIDTH-1:0] rem_signed;

  assign start_div0 = (i_divisor == '0);
  assign start_ovf  = i_signed && (i_dividend == MinVal) && (i_divisor == '1);

  assign dividend_mag = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign divisor_mag  = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder.
  assign shifted  = {rem_q, quot_q[WIDTH-1]};
  assign step_ge  = (shifted >= {1'b0, divisor_q});
  assign rem_nxt  = step_ge ? (shifted[WIDTH-1:0] - divisor_q) : shifted[WIDTH-1:0];
  assign quot_nxt = {quot_q[WIDTH-2:0], step_ge};

  assign quot_signed = neg_q_q ? -quot_nxt : quot_nxt;
  assign rem_signed  = neg_r_q ? -rem_nxt  : rem_nxt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d    = StCalc;
          cnt_d      = '0;
          rem_d      = '0;
          quot_d     = dividend_mag;
          divisor_d  = divisor_mag;
          dividend_d = i_dividend;
          neg_q_d    = i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
          neg_r_d    = i_signed && i_dividend[WIDTH-1];
          div0_d     = start_div0;
          ovf_d      = start_ovf;
`ifdef DIV_SPECIAL_FAST_EN
          if (start_div0 || start_ovf) begin
            state_d     = StDone;
            quotient_d  = start_ovf ? MinVal : '1;
            remainder_d = start_ovf ? '0 : i_dividend;
          end
`endif
        end
      end
      StCalc: begin
        rem_d  = rem_nxt;
        quot_d = quot_nxt;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
          if (div0_q) begin
            quotient_d  = '1;
            remainder_d = dividend_q;
          end else if (ovf_q) begin
            quotient_d  = MinVal;
            remainder_d = '0;
          end else begin
            quotient_d  = quot_signed;
            remainder_d = rem_signed;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush wins over everything except reset; results from the last completed divide survive.
    if (i_flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      divisor_q   <= divisor_d;
      dividend_q  <= dividend_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign o_busy      = (state_q == StCalc);
  assign o_end_valid = (state_q == StDone) && !i_flush;
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32), honouring DIV_SPECIAL_FAST_EN.
module tb_seq_divider;

  localparam int W = 32;
`ifdef DIV_SPECIAL_FAST_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = W + 1;
`endif

  logic         clk;
  logic         reset;
  logic         i_flush;
  logic         i_start;
  logic         i_signed;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_end_valid;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (i_flush),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_end_valid (o_end_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is in an IDLE cycle. Returns in the IDLE cycle right after DONE.
  // poke_at > 0 pulses a stray start (50/5) at that cycle offset.
  task automatic run_div(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat, input int poke_at);
    int  k;
    int  busy_cnt;
    bit  seen;
    i_start    = 1'b1;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    tick();
    i_start  = 1'b0;
    k        = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && k <= 40) begin
      if (o_busy) busy_cnt++;
      if (o_end_valid) begin
        seen = 1'b1;
      end else begin
        if (k == poke_at) begin
          i_start    = 1'b1;
          i_dividend = 32'd50;
          i_divisor  = 32'd5;
        end
        tick();
        i_start = 1'b0;
        k++;
      end
    end
    checks++;
    if (!seen || k != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, k, seen, lat);
    end
    checks++;
    if (busy_cnt != lat - 1) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat - 1);
    end
    checks++;
    if (o_quotient !== eq) begin
      errors++;
      $display("FAIL %s quotient: got %h expected %h", name, o_quotient, eq);
    end
    checks++;
    if (o_remainder !== er) begin
      errors++;
      $display("FAIL %s remainder: got %h expected %h", name, o_remainder, er);
    end
    tick();
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (o_busy !== 1'b0 || o_end_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s ctrl: got busy=%b valid=%b expected 0 0", name, o_busy, o_end_valid);
    end
    checks++;
    if (o_quotient !== '0 || o_remainder !== '0) begin
      errors++;
      $display("FAIL %s data: got q=%h r=%h expected 0 0", name, o_quotient, o_remainder);
    end
  endtask

  task automatic watch_no_valid(input string name, input int n);
    bit hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (o_end_valid || o_busy) hit = 1'b1;
      tick();
    end
    checks++;
    if (hit) begin
      errors++;
      $display("FAIL %s idle: got activity=1 expected 0", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_outputs_zero("reset");
  endtask

  task automatic test_unsigned();
    run_div("u_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, W + 1, 0);
    run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, W + 1, 0);
    run_div("u_0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, W + 1, 0);
    run_div("u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, W + 1, 0);
  endtask

  task automatic test_signed();
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, W + 1, 0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, W + 1, 0);
    run_div("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, W + 1, 0);
  endtask

  task automatic test_special();
    run_div("s_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, SpecLat, 0);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, SpecLat, 0);
    run_div("u_9_0", 1'b0, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, SpecLat, 0);
    run_div("s_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, SpecLat, 0);
  endtask

  // Prior result here is from s_m5_0.
  task automatic test_flush();
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'd100;
    i_divisor  = 32'd7;
    tick();
    i_start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_end_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ctrl: got busy=%b valid=%b expected 0 0", o_busy, o_end_valid);
    end
    checks++;
    if (o_quotient !== 32'hFFFFFFFF || o_remainder !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL flush_hold: got q=%h r=%h expected ffffffff fffffffb",
               o_quotient, o_remainder);
    end
    run_div("after_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, W + 1, 0);
  endtask

  task automatic test_ignore_start();
    run_div("busy_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, W + 1, 4);
    i_start    = 1'b1;
    i_flush    = 1'b1;
    i_dividend = 32'd50;
    i_divisor  = 32'd5;
    tick();
    i_start = 1'b0;
    i_flush = 1'b0;
    watch_no_valid("flush_start", 40);
    checks++;
    if (o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
      errors++;
      $display("FAIL hold_results: got q=%h r=%h expected e 2", o_quotient, o_remainder);
    end
  endtask

  task automatic test_back_to_back();
    run_div("b2b_a", 1'b1, 32'hFFFFFF9C, 32'd10, 32'hFFFFFFF6, 32'd0, W + 1, 0);
    run_div("b2b_b", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, W + 1, 0);
  endtask

  task automatic test_reset_mid();
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'd100;
    i_divisor  = 32'd7;
    tick();
    i_start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs_zero("reset_mid");
    watch_no_valid("reset_mid_idle", 40);
  endtask

  initial begin
    reset      = 1'b1;
    i_flush    = 1'b0;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
